// File: rtl/act_ctrl_sched.sv
// rtl/act_ctrl_sched.sv - LUT-load / compute sequencer for the activation core.
// Define ACT_CTRL_PERF_EN to add the perf_jobs / perf_stall counters.
module act_ctrl_sched #(
    parameter int DATA_WIDTH     = 32,
    parameter int LUT_ADDR_WIDTH = 8,
    parameter int LUT_DEPTH      = 256,
    parameter int EXP_BUF_SIZE   = 8,
    parameter int MAX_INFLIGHT   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [DATA_WIDTH-1:0]     cfg_data,
    input  logic                      cfg_last,
    input  logic                      job_valid,
    output logic                      job_ready,
    input  logic                      job_mode,
    input  logic [DATA_WIDTH-1:0]     job_data,
    output logic                      acc_in_valid,
    output logic                      acc_in_mode_sel,
    output logic [DATA_WIDTH-1:0]     acc_in_data,
    output logic                      acc_lut_wr_en,
    output logic [LUT_ADDR_WIDTH-1:0] acc_lut_wr_addr,
    output logic [DATA_WIDTH-1:0]     acc_lut_data,
    input  logic                      acc_out_valid,
    output logic                      busy,
    output logic                      lut_loaded
`ifdef ACT_CTRL_PERF_EN
    ,
    output logic [31:0]               perf_jobs,
    output logic [31:0]               perf_stall
`endif
);

    localparam int IW = $clog2(MAX_INFLIGHT + 1);
    localparam int GW = (EXP_BUF_SIZE > 1) ? $clog2(EXP_BUF_SIZE) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_LOAD  = 2'd3
    } state_t;

    state_t                    state;
    state_t                    state_nxt;
    logic [IW-1:0]             inflight;
    logic [IW-1:0]             inflight_nxt;
    logic [GW-1:0]             grp_cnt;
    logic [LUT_ADDR_WIDTH-1:0] wr_addr;
    logic                      cur_mode;

    logic job_fire;
    logic cfg_fire;
    logic out_ret;
    logic room;
    logic mode_ok;
    logic grp_zero;
    logic last_addr;

    assign grp_zero  = (grp_cnt == '0);
    assign last_addr = (wr_addr == LUT_ADDR_WIDTH'(LUT_DEPTH - 1));
    // A return in the same cycle frees a slot, so a full pipe can still admit.
    assign room      = (inflight < IW'(MAX_INFLIGHT)) || acc_out_valid;
    assign mode_ok   = (job_mode == cur_mode) || ((inflight == '0) && grp_zero);
    assign job_fire  = job_valid && job_ready;
    assign cfg_fire  = cfg_valid && cfg_ready;
    // Spurious returns with nothing outstanding are dropped.
    assign out_ret   = acc_out_valid && (inflight != '0);

    always_comb begin
        inflight_nxt = inflight;
        if (job_fire && !out_ret) begin
            inflight_nxt = inflight + IW'(1);
        end else if (!job_fire && out_ret) begin
            inflight_nxt = inflight - IW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (cfg_valid) begin
                    state_nxt = S_DRAIN;
                end else if (job_valid && lut_loaded) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                // An open softmax group must close before leaving RUN.
                if (cfg_valid && grp_zero) begin
                    state_nxt = S_DRAIN;
                end else if (!job_valid && grp_zero) begin
                    state_nxt = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (inflight_nxt == '0) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (cfg_fire && (last_addr || cfg_last)) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cfg_ready = 1'b0;
        job_ready = 1'b0;
        busy      = (state != S_IDLE) || (inflight != '0);
        case (state)
            S_RUN:   job_ready = room && mode_ok && !(cfg_valid && grp_zero);
            S_LOAD:  cfg_ready = 1'b1;
            default: begin
                cfg_ready = 1'b0;
                job_ready = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight        <= '0;
            grp_cnt         <= '0;
            wr_addr         <= '0;
            cur_mode        <= 1'b0;
            lut_loaded      <= 1'b0;
            acc_in_valid    <= 1'b0;
            acc_in_mode_sel <= 1'b0;
            acc_in_data     <= '0;
            acc_lut_wr_en   <= 1'b0;
            acc_lut_wr_addr <= '0;
            acc_lut_data    <= '0;
        end else begin
            inflight      <= inflight_nxt;
            acc_in_valid  <= job_fire;
            acc_lut_wr_en <= cfg_fire;

            if (job_fire) begin
                acc_in_data     <= job_data;
                acc_in_mode_sel <= job_mode;
                cur_mode        <= job_mode;
                if (job_mode) begin
                    grp_cnt <= (grp_cnt == GW'(EXP_BUF_SIZE - 1)) ? '0 : grp_cnt + GW'(1);
                end else begin
                    grp_cnt <= '0;
                end
            end

            if (cfg_fire) begin
                acc_lut_wr_addr <= wr_addr;
                acc_lut_data    <= cfg_data;
                if (last_addr) begin
                    lut_loaded <= 1'b1;
                end else begin
                    wr_addr <= wr_addr + LUT_ADDR_WIDTH'(1);
                end
            end

            // The old image is invalid from the moment the rewrite begins.
            if ((state == S_DRAIN) && (state_nxt == S_LOAD)) begin
                lut_loaded <= 1'b0;
                wr_addr    <= '0;
            end
        end
    end

`ifdef ACT_CTRL_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_jobs  <= '0;
            perf_stall <= '0;
        end else begin
            if (job_fire && (perf_jobs != '1)) begin
                perf_jobs <= perf_jobs + 32'd1;
            end
            if (job_valid && !job_ready && (perf_stall != '1)) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_act_ctrl_sched.sv
// tb/tb_act_ctrl_sched.sv - directed bench with a cycle-level handshake model for act_ctrl_sched.
module tb_act_ctrl_sched;

    localparam int DW    = 32;
    localparam int AW    = 8;
    localparam int DEPTH = 256;
    localparam int EXP   = 8;
    localparam int MAXI  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [DW-1:0] cfg_data = '0;
    logic          cfg_last = 1'b0;
    logic          job_valid = 1'b0;
    logic          job_ready;
    logic          job_mode = 1'b0;
    logic [DW-1:0] job_data = '0;
    logic          acc_in_valid;
    logic          acc_in_mode_sel;
    logic [DW-1:0] acc_in_data;
    logic          acc_lut_wr_en;
    logic [AW-1:0] acc_lut_wr_addr;
    logic [DW-1:0] acc_lut_data;
    logic          acc_out_valid = 1'b0;
    logic          busy;
    logic          lut_loaded;
`ifdef ACT_CTRL_PERF_EN
    logic [31:0]   perf_jobs;
    logic [31:0]   perf_stall;
`endif

    act_ctrl_sched #(
        .DATA_WIDTH(DW), .LUT_ADDR_WIDTH(AW), .LUT_DEPTH(DEPTH),
        .EXP_BUF_SIZE(EXP), .MAX_INFLIGHT(MAXI)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data), .cfg_last(cfg_last),
        .job_valid(job_valid), .job_ready(job_ready), .job_mode(job_mode), .job_data(job_data),
        .acc_in_valid(acc_in_valid), .acc_in_mode_sel(acc_in_mode_sel), .acc_in_data(acc_in_data),
        .acc_lut_wr_en(acc_lut_wr_en), .acc_lut_wr_addr(acc_lut_wr_addr), .acc_lut_data(acc_lut_data),
        .acc_out_valid(acc_out_valid), .busy(busy), .lut_loaded(lut_loaded)
`ifdef ACT_CTRL_PERF_EN
        , .perf_jobs(perf_jobs), .perf_stall(perf_stall)
`endif
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Model state: what the outputs must be, derived from observed handshakes.
    int            inf_m    = 0;
    int            grp_m    = 0;
    logic          cur_m    = 1'b0;
    int            addr_m   = 0;
    logic          loaded_m = 1'b0;
    logic          known    = 1'b1;
    logic          exp_iv   = 1'b0;
    logic          exp_md   = 1'b0;
    logic [DW-1:0] exp_d    = '0;
    logic          exp_wr   = 1'b0;
    int            exp_addr = 0;
    logic [DW-1:0] exp_ld   = '0;
    int            wr_cnt   = 0;

    always @(negedge clk) begin
        logic jhs;
        logic chs;
        logic ok;
        if (rst) begin
            chk("rst_in_valid", 32'(acc_in_valid), 0);
            chk("rst_wr_en", 32'(acc_lut_wr_en), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_lut_loaded", 32'(lut_loaded), 0);
            chk("rst_wr_addr", 32'(acc_lut_wr_addr), 0);
            chk("rst_in_data", acc_in_data, 0);
            inf_m = 0; grp_m = 0; cur_m = 0; addr_m = 0;
            loaded_m = 0; known = 1; exp_iv = 0; exp_wr = 0;
        end else begin
            chk("in_valid", 32'(acc_in_valid), 32'(exp_iv));
            if (exp_iv) begin
                chk("in_data", acc_in_data, exp_d);
                chk("in_mode_sel", 32'(acc_in_mode_sel), 32'(exp_md));
            end
            chk("lut_wr_en", 32'(acc_lut_wr_en), 32'(exp_wr));
            if (exp_wr) begin
                chk("lut_wr_addr", 32'(acc_lut_wr_addr), 32'(exp_addr));
                chk("lut_data", acc_lut_data, exp_ld);
            end
            if (acc_lut_wr_en) wr_cnt++;
            if (known) chk("lut_loaded", 32'(lut_loaded), 32'(loaded_m));
            chk("ready_exclusive", 32'(cfg_ready && job_ready), 0);
            if (inf_m != 0) chk("busy_inflight", 32'(busy), 1);

            jhs = job_valid && job_ready;
            chs = cfg_valid && cfg_ready;
            if (jhs) begin
                ok = lut_loaded && ((inf_m < MAXI) || acc_out_valid) &&
                     ((job_mode == cur_m) || (inf_m == 0 && grp_m == 0));
                chk("job_accept_rules", 32'(ok), 1);
            end
            if (chs) chk("loading_lut_loaded", 32'(lut_loaded), 0);
            if (cfg_valid && !chs) known = 0;

            if (acc_out_valid && inf_m > 0) inf_m--;
            exp_iv = jhs;
            if (jhs) begin
                inf_m++;
                exp_d  = job_data;
                exp_md = job_mode;
                cur_m  = job_mode;
                grp_m  = job_mode ? (grp_m + 1) % EXP : 0;
            end
            exp_wr = chs;
            if (chs) begin
                exp_addr = addr_m;
                exp_ld   = cfg_data;
                if (addr_m == DEPTH - 1) begin
                    loaded_m = 1; known = 1; addr_m = 0;
                end else if (cfg_last) begin
                    loaded_m = 0; known = 1; addr_m = 0;
                end else begin
                    addr_m++;
                end
            end
        end
    end

    task automatic send_cfg(input logic [DW-1:0] d, input logic last);
        int n = 0;
        cfg_valid = 1'b1; cfg_data = d; cfg_last = last;
        @(negedge clk);
        while (!cfg_ready && n < 200) begin n++; @(negedge clk); end
        chk("cfg_wait", 32'(cfg_ready), 1);
        @(posedge clk); #1;
        cfg_valid = 1'b0; cfg_last = 1'b0;
    endtask

    task automatic send_job(input logic m, input logic [DW-1:0] d);
        int n = 0;
        job_valid = 1'b1; job_mode = m; job_data = d;
        @(negedge clk);
        while (!job_ready && n < 200) begin n++; @(negedge clk); end
        chk("job_wait", 32'(job_ready), 1);
        @(posedge clk); #1;
        job_valid = 1'b0;
    endtask

    task automatic out_pulse();
        acc_out_valid = 1'b1;
        @(posedge clk); #1;
        acc_out_valid = 1'b0;
    endtask

    initial begin
        int acc;
        int w0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_cfg_ready", 32'(cfg_ready), 0);
        chk("reset_job_ready", 32'(job_ready), 0);
        chk("reset_lut_loaded", 32'(lut_loaded), 0);

        // Job without a LUT image is held off.
        @(posedge clk); #1;
        job_valid = 1'b1; job_mode = 1'b0; job_data = 32'h3F80_0000;
        acc = 0;
        repeat (20) begin @(negedge clk); if (job_ready) acc++; end
        chk("no_lut_hold", 32'(acc), 0);
        @(posedge clk); #1 job_valid = 1'b0;

        // Full image, data = address.
        w0 = wr_cnt;
        for (int i = 0; i < DEPTH; i++) send_cfg(32'(i), i == DEPTH - 1);
        @(negedge clk);
        chk("full_last_addr", 32'(acc_lut_wr_addr), 255);
        chk("full_lut_loaded", 32'(lut_loaded), 1);
        chk("full_busy", 32'(busy), 0);
        @(negedge clk);
        chk("full_pulse_count", 32'(wr_cnt - w0), 256);

        @(posedge clk); #1;
        send_job(1'b0, 32'h3F80_0000);
        @(negedge clk);
        chk("first_job_valid", 32'(acc_in_valid), 1);
        chk("first_job_data", acc_in_data, 32'h3F80_0000);
        chk("first_job_mode", 32'(acc_in_mode_sel), 0);
        @(posedge clk); #1;
        out_pulse();

        // In-flight limit with no returns.
        job_valid = 1'b1; job_mode = 1'b0; job_data = 32'h100;
        acc = 0;
        repeat (15) begin @(negedge clk); if (job_ready) acc++; end
        chk("max_inflight_accepts", 32'(acc), 4);
        @(posedge clk); #1 acc_out_valid = 1'b1;
        @(negedge clk);
        chk("admit_on_return", 32'(job_ready), 1);
        @(posedge clk); #1;
        acc_out_valid = 1'b0; job_valid = 1'b0;
        repeat (4) out_pulse();
        @(negedge clk);
        chk("drained_busy", 32'(busy), 0);
        @(posedge clk); #1;

        // Softmax group atomicity.
        for (int i = 0; i < 3; i++) begin send_job(1'b1, 32'(32'h200 + i)); out_pulse(); end
        job_valid = 1'b1; job_mode = 1'b0; job_data = 32'h2FF;
        acc = 0;
        repeat (5) begin @(negedge clk); if (job_ready) acc++; end
        chk("mismatch_stall_grp", 32'(acc), 0);
        @(posedge clk); #1 job_valid = 1'b0;
        for (int i = 3; i < EXP; i++) begin
            send_job(1'b1, 32'(32'h200 + i));
            if (i < EXP - 1) out_pulse();
        end
        job_valid = 1'b1; job_mode = 1'b0; job_data = 32'h3FF;
        acc = 0;
        repeat (3) begin @(negedge clk); if (job_ready) acc++; end
        chk("mismatch_stall_inflight", 32'(acc), 0);
        @(posedge clk); #1;
        out_pulse();
        send_job(1'b0, 32'h3FF);
        @(negedge clk);
        chk("switch_valid", 32'(acc_in_valid), 1);
        chk("switch_mode_sel", 32'(acc_in_mode_sel), 0);
        chk("switch_data", acc_in_data, 32'h3FF);
        @(posedge clk); #1;
        out_pulse();

        // Reload requested while 3 elements are outstanding, then a short load.
        send_job(1'b0, 32'h500);
        send_job(1'b0, 32'h501);
        send_job(1'b0, 32'h502);
        cfg_valid = 1'b1; cfg_data = 32'd0; cfg_last = 1'b0;
        w0 = wr_cnt;
        repeat (3) begin repeat (2) @(posedge clk); #1; out_pulse(); end
        @(negedge clk);
        chk("drain_no_write", 32'(wr_cnt - w0), 0);
        chk("drain_cfg_ready", 32'(cfg_ready), 1);
        @(posedge clk); #1;
        for (int i = 1; i <= 10; i++) send_cfg(32'(i), i == 10);
        @(negedge clk);
        chk("short_last_addr", 32'(acc_lut_wr_addr), 10);
        chk("short_lut_loaded", 32'(lut_loaded), 0);
        chk("short_busy", 32'(busy), 0);

        // Reset in the middle of a load.
        @(posedge clk); #1;
        for (int i = 0; i < 100; i++) send_cfg(32'(1000 + i), 1'b0);
        rst = 1'b1;
        #2;
        chk("async_wr_en", 32'(acc_lut_wr_en), 0);
        chk("async_wr_addr", 32'(acc_lut_wr_addr), 0);
        chk("async_lut_data", acc_lut_data, 0);
        chk("async_cfg_ready", 32'(cfg_ready), 0);
        chk("async_busy", 32'(busy), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        send_cfg(32'h77, 1'b0);
        @(negedge clk);
        chk("reload_wr_en", 32'(acc_lut_wr_en), 1);
        chk("reload_addr", 32'(acc_lut_wr_addr), 0);
        chk("reload_data", acc_lut_data, 32'h77);

        @(posedge clk); #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/act_ctrl_sched.md
Name: act_ctrl_sched

Overview:
Controller in front of the activation accelerator core. It sequences LUT programming and compute traffic into the core's in_valid/in_mode_sel/in_data and lut_wr_en/lut_wr_addr/lut_data ports. It tracks in-flight elements against the core's out_valid, and drains the pipeline before any LUT rewrite or mode switch. It keeps softmax (mode 1) groups of EXP_BUF_SIZE elements atomic.

Parameters:
DATA_WIDTH, 32, data and LUT word width
LUT_ADDR_WIDTH, 8, LUT address width
LUT_DEPTH, 256, number of LUT entries; a load is complete after the last entry is written
EXP_BUF_SIZE, 8, elements per softmax group (mode 1)
MAX_INFLIGHT, 4, maximum elements issued to the core and not yet returned

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
cfg_valid  input  1  LUT load word valid
cfg_ready  output  1  LUT load word accepted when high together with cfg_valid
cfg_data  input  DATA_WIDTH  LUT word
cfg_last  input  1  last word of the load burst
job_valid  input  1  compute element valid
job_ready  output  1  compute element accepted
job_mode  input  1  0 = elementwise LUT activation, 1 = softmax
job_data  input  DATA_WIDTH  element
acc_in_valid  output  1  to core in_valid
acc_in_mode_sel  output  1  to core in_mode_sel
acc_in_data  output  DATA_WIDTH  to core in_data
acc_lut_wr_en  output  1  to core lut_wr_en
acc_lut_wr_addr  output  LUT_ADDR_WIDTH  to core lut_wr_addr
acc_lut_data  output  DATA_WIDTH  to core lut_data
acc_out_valid  input  1  from core out_valid, one result returned
busy  output  1  state != IDLE or inflight != 0
lut_loaded  output  1  LUT holds a complete image

Behaviour:
- Reset: state=IDLE and cur_mode=0. inflight, grp_cnt and wr_addr are 0. All outputs are 0, including the data and address buses.
- acc_* outputs are registered. A handshake in cycle N produces the core strobe in cycle N+1 and the strobe lasts exactly one cycle.
- inflight counter: +1 on acc_in_valid, -1 on acc_out_valid. Both in the same cycle leave it unchanged. acc_out_valid with inflight=0 is ignored and the counter stays at 0.
- States:
  - IDLE: cfg_valid has priority and moves to DRAIN. Otherwise, job_valid with lut_loaded=1 moves to RUN. job_valid with lut_loaded=0 is held (job_ready=0).
  - RUN: the condition for job_ready is described below. cfg_valid moves to DRAIN, and job_ready drops in the same cycle only if grp_cnt=0; otherwise the group is finished first. job_valid=0 with grp_cnt=0 returns to IDLE.
  - DRAIN: job_ready=0 and cfg_ready=0. When inflight=0 (counter value after update), go to LOAD, clear lut_loaded, and set wr_addr=0.
  - LOAD: cfg_ready=1. Each accepted word writes wr_addr and then increments it.
    - Write at address LUT_DEPTH-1: set lut_loaded and go to IDLE. A cfg_last on that word is redundant.
    - cfg_last on an earlier word: the word is written, lut_loaded stays 0, and the state goes to IDLE (short load).
    - wr_addr never wraps.
- job_ready in RUN is asserted only when all of the following hold:
  - inflight < MAX_INFLIGHT, or acc_out_valid is high this cycle.
  - job_mode == cur_mode, or the mode switch is legal: inflight=0 and grp_cnt=0, in which case cur_mode takes job_mode on acceptance.
  - In mode 1 with grp_cnt != 0, job_mode must equal cur_mode. Mismatched elements are stalled and never dropped.
- grp_cnt counts accepted mode-1 elements modulo EXP_BUF_SIZE. It stays 0 in mode 0.
- acc_in_mode_sel equals cur_mode for the issued element.
- cfg_ready and job_ready are never both 1.
- Asynchronous reset during LOAD or with elements in flight returns everything to the reset values. lut_loaded=0 after reset.

Optional Feature:
ACT_CTRL_PERF_EN: when defined, adds the following output ports:
- perf_jobs (32 bits): count of accepted job handshakes.
- perf_stall (32 bits): cycles with job_valid=1 and job_ready=0.
Both counters saturate at all-ones and reset to 0. When the macro is undefined, the ports and logic are absent and all other behaviour is identical.

Test Plan:
- Reset, then load 256 words (data=addr): acc_lut_wr_en pulses 256 times with addr 0..255, each one cycle after its handshake. lut_loaded=1 after the last word, state returns to IDLE, busy=0.
- Job with lut_loaded=0: job_ready stays 0 for 20 cycles. After a full load, a mode-0 job with data 0x3F800000 appears on acc_in_data one cycle after the handshake, with acc_in_mode_sel=0.
- MAX_INFLIGHT=4, acc_out_valid tied low, stream 6 mode-0 jobs: exactly 4 are accepted. One acc_out_valid pulse admits the 5th in the same cycle.
- Three mode-1 jobs, then job_mode=0 presented: stalled until the group reaches 8 and inflight returns to 0. It is then accepted with acc_in_mode_sel=0.
- cfg_valid raised in RUN with inflight=3: no acc_lut_wr_en until 3 acc_out_valid pulses. cfg_last on word 10 gives lut_loaded=0 and IDLE.
- Assert rst mid-LOAD at wr_addr=100: all outputs 0 immediately. A new load starts at address 0.
